// File: rtl/button_debounce.sv
// Module: button_debounce
//
// Conditions the push-button pad inputs. Each raw input goes through a
// 2-flop synchroniser and then into its own debounce FSM. The FSM produces
// a clean level and single-cycle press, release and long-press pulses.
//
// Ports:
//   clk          in   1      system clock; all logic is on posedge
//   rst          in   1      synchronous, active-high reset
//   btn_raw      in   N_BTN  raw asynchronous pad inputs, 1 = pressed
//   btn_level    out  N_BTN  debounced level, 1 = pressed
//   btn_press    out  N_BTN  1-cycle pulse when a press is accepted
//   btn_release  out  N_BTN  1-cycle pulse when a release is accepted
//   btn_long     out  N_BTN  1-cycle pulse, once per press, LONG_CYCLES after btn_press
module button_debounce #(
   parameter int N_BTN           = 2,
   parameter int DEBOUNCE_CYCLES = 120000,
   parameter int LONG_CYCLES     = 12000000
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N_BTN-1:0] btn_raw,
   output logic [N_BTN-1:0] btn_level,
   output logic [N_BTN-1:0] btn_press,
   output logic [N_BTN-1:0] btn_release,
   output logic [N_BTN-1:0] btn_long
);

   localparam int DEB_W  = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam int HOLD_W = $clog2(LONG_CYCLES + 1);

   localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_CYCLES);
   localparam logic [HOLD_W-1:0] HOLD_FIRE = HOLD_W'(LONG_CYCLES - 1);

   typedef enum logic [1:0] {
      RELEASED     = 2'd0,
      PRESS_WAIT   = 2'd1,
      PRESSED      = 2'd2,
      RELEASE_WAIT = 2'd3
   } state_t;

   // Two-flop synchroniser. Nothing downstream looks at btn_raw directly.
   logic [N_BTN-1:0] sync1_reg;
   logic [N_BTN-1:0] btn_sync;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_reg <= '0;
         btn_sync  <= '0;
      end else begin
         sync1_reg <= btn_raw;
         btn_sync  <= sync1_reg;
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < N_BTN; gi++) begin : g_btn
         state_t             state_reg, state_next;
         logic [DEB_W-1:0]   deb_reg, deb_next;
         logic [HOLD_W-1:0]  hold_reg, hold_next, hold_inc;
         logic               long_done_reg, long_done_next;
         logic               level_reg, level_next;
         logic               press_reg, press_next;
         logic               release_reg, release_next;
         logic               long_reg, long_next;

         always_ff @(posedge clk) begin
            if (rst) begin
               state_reg     <= RELEASED;
               deb_reg       <= '0;
               hold_reg      <= '0;
               long_done_reg <= 1'b0;
               level_reg     <= 1'b0;
               press_reg     <= 1'b0;
               release_reg   <= 1'b0;
               long_reg      <= 1'b0;
            end else begin
               state_reg     <= state_next;
               deb_reg       <= deb_next;
               hold_reg      <= hold_next;
               long_done_reg <= long_done_next;
               level_reg     <= level_next;
               press_reg     <= press_next;
               release_reg   <= release_next;
               long_reg      <= long_next;
            end
         end

         // Saturating increment so a very long hold never wraps back to zero.
         assign hold_inc = (hold_reg == HOLD_MAX) ? hold_reg : hold_reg + 1'b1;

         always_comb begin
            state_next     = state_reg;
            deb_next       = deb_reg;
            hold_next      = hold_reg;
            long_done_next = long_done_reg;
            level_next     = level_reg;
            press_next     = 1'b0;
            release_next   = 1'b0;
            long_next      = 1'b0;

            case (state_reg)
               RELEASED: begin
                  if (btn_sync[gi]) begin
                     state_next = PRESS_WAIT;
                     deb_next   = '0;
                  end
               end
               PRESS_WAIT: begin
                  if (!btn_sync[gi]) begin
                     state_next = RELEASED;       // bounce: drop silently
                  end else if (deb_reg == DEB_LAST) begin
                     state_next     = PRESSED;
                     press_next     = 1'b1;
                     level_next     = 1'b1;
                     hold_next      = '0;
                     long_done_next = 1'b0;
                  end else begin
                     deb_next = deb_reg + 1'b1;
                  end
               end
               PRESSED: begin
                  hold_next = hold_inc;
                  if (!btn_sync[gi]) begin
                     state_next = RELEASE_WAIT;
                     deb_next   = '0;
                  end
               end
               RELEASE_WAIT: begin
                  // The hold time keeps running through a release glitch so
                  // the long-press timing is not disturbed by it.
                  hold_next = hold_inc;
                  if (btn_sync[gi]) begin
                     state_next = PRESSED;
                  end else if (deb_reg == DEB_LAST) begin
                     state_next   = RELEASED;
                     release_next = 1'b1;
                     level_next   = 1'b0;
                  end else begin
                     deb_next = deb_reg + 1'b1;
                  end
               end
               default: begin
                  state_next = RELEASED;
               end
            endcase

            // hold_reg counts from 0 at the press edge, so it steps to
            // LONG_CYCLES exactly LONG_CYCLES cycles after btn_press.
            // A release accepted on the same edge suppresses the pulse.
            if (((state_reg == PRESSED) || (state_reg == RELEASE_WAIT)) &&
                !long_done_reg && !release_next && (hold_reg == HOLD_FIRE)) begin
               long_next      = 1'b1;
               long_done_next = 1'b1;
            end
         end

         assign btn_level[gi]   = level_reg;
         assign btn_press[gi]   = press_reg;
         assign btn_release[gi] = release_reg;
         assign btn_long[gi]    = long_reg;
      end
   endgenerate

endmodule

// File: tb/tb_button_debounce.sv
// Testbench for button_debounce with N_BTN=2, DEBOUNCE_CYCLES=4, LONG_CYCLES=20.
// Inputs are driven and outputs sampled 1 time unit after each posedge. A
// negedge monitor keeps cumulative pulse counts and the edge number of the
// most recent pulse for each bit. Tests snapshot the counts and compare
// the differences against hand-computed expectations.
module tb_button_debounce;

   localparam int NB   = 2;
   localparam int DEB  = 4;
   localparam int LONG = 20;
   localparam int LAT  = DEB + 2;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [NB-1:0] btn_raw = '0;
   logic [NB-1:0] btn_level, btn_press, btn_release, btn_long;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   int press_n [NB] = '{0, 0};
   int rel_n   [NB] = '{0, 0};
   int long_n  [NB] = '{0, 0};
   int press_at[NB] = '{0, 0};
   int rel_at  [NB] = '{0, 0};
   int long_at [NB] = '{0, 0};
   int viol         = 0;
   logic [NB-1:0] prev_press = '0, prev_rel = '0, prev_long = '0;

   button_debounce #(
      .N_BTN(NB), .DEBOUNCE_CYCLES(DEB), .LONG_CYCLES(LONG)
   ) dut (
      .clk(clk), .rst(rst), .btn_raw(btn_raw),
      .btn_level(btn_level), .btn_press(btn_press),
      .btn_release(btn_release), .btn_long(btn_long)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // cyc equals the number of the most recent posedge here.
   always @(negedge clk) begin
      for (int b = 0; b < NB; b++) begin
         if (btn_press[b])   begin press_n[b]++; press_at[b] = cyc; end
         if (btn_release[b]) begin rel_n[b]++;   rel_at[b]   = cyc; end
         if (btn_long[b])    begin long_n[b]++;  long_at[b]  = cyc; end
         if (btn_press[b] && btn_release[b]) viol++;
         if ((btn_press[b] && prev_press[b]) || (btn_release[b] && prev_rel[b]) ||
             (btn_long[b] && prev_long[b])) viol++;
      end
      prev_press = btn_press;
      prev_rel   = btn_release;
      prev_long  = btn_long;
   end

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      btn_raw = '0;
      tick(3);
      checks++; if (btn_level !== 2'b00) begin failures++; $display("FAIL reset_level got=%b exp=00", btn_level); end
      checks++; if (btn_press !== 2'b00) begin failures++; $display("FAIL reset_press got=%b exp=00", btn_press); end
      checks++; if (btn_release !== 2'b00) begin failures++; $display("FAIL reset_release got=%b exp=00", btn_release); end
      checks++; if (btn_long !== 2'b00) begin failures++; $display("FAIL reset_long got=%b exp=00", btn_long); end
      rst = 1'b0;
      tick(2);
      $display("test_reset: outputs idle after reset");
   endtask

   task automatic test_clean_press();
      int t0, p0, p1, r0, l0;
      p0 = press_n[0]; p1 = press_n[1]; r0 = rel_n[0]; l0 = long_n[0];
      t0 = cyc;
      btn_raw = 2'b01;
      tick(10);
      checks++; if (press_n[0] - p0 !== 1) begin failures++; $display("FAIL clean_press_count got=%0d exp=1", press_n[0] - p0); end
      checks++; if (press_at[0] !== t0 + 1 + LAT) begin failures++; $display("FAIL clean_press_latency got=%0d exp=%0d", press_at[0] - t0 - 1, LAT); end
      checks++; if (btn_level !== 2'b01) begin failures++; $display("FAIL clean_press_level got=%b exp=01", btn_level); end
      checks++; if (press_n[1] !== p1) begin failures++; $display("FAIL idle_bit1_press got=%0d exp=0", press_n[1] - p1); end
      t0 = cyc;
      btn_raw = 2'b00;
      tick(10);
      checks++; if (rel_n[0] - r0 !== 1) begin failures++; $display("FAIL clean_release_count got=%0d exp=1", rel_n[0] - r0); end
      checks++; if (rel_at[0] !== t0 + 1 + LAT) begin failures++; $display("FAIL clean_release_latency got=%0d exp=%0d", rel_at[0] - t0 - 1, LAT); end
      checks++; if (btn_level !== 2'b00) begin failures++; $display("FAIL clean_release_level got=%b exp=00", btn_level); end
      checks++; if (long_n[0] !== l0) begin failures++; $display("FAIL short_press_no_long got=%0d exp=0", long_n[0] - l0); end
      $display("test_clean_press: press and release pulses checked");
   endtask

   task automatic test_bounce();
      int p0, r0;
      p0 = press_n[0]; r0 = rel_n[0];
      btn_raw = 2'b01; tick(2); btn_raw = 2'b00; tick(2);
      btn_raw = 2'b01; tick(2); btn_raw = 2'b00; tick(12);
      checks++; if (press_n[0] !== p0) begin failures++; $display("FAIL bounce_low_press got=%0d exp=0", press_n[0] - p0); end
      checks++; if (btn_level[0] !== 1'b0) begin failures++; $display("FAIL bounce_low_level got=%b exp=0", btn_level[0]); end
      btn_raw = 2'b01; tick(2); btn_raw = 2'b00; tick(2);
      btn_raw = 2'b01; tick(2); btn_raw = 2'b00; tick(2);
      btn_raw = 2'b01; tick(10);
      checks++; if (press_n[0] - p0 !== 1) begin failures++; $display("FAIL bounce_high_press got=%0d exp=1", press_n[0] - p0); end
      checks++; if (btn_level[0] !== 1'b1) begin failures++; $display("FAIL bounce_high_level got=%b exp=1", btn_level[0]); end
      btn_raw = 2'b00; tick(12);
      checks++; if (rel_n[0] - r0 !== 1) begin failures++; $display("FAIL bounce_release got=%0d exp=1", rel_n[0] - r0); end
      $display("test_bounce: bounced edges checked");
   endtask

   task automatic test_long_press();
      int t0, t1, l0;
      l0 = long_n[0];
      t0 = cyc;
      btn_raw = 2'b01;
      tick(40);
      checks++; if (press_at[0] !== t0 + 1 + LAT) begin failures++; $display("FAIL long_press_latency got=%0d exp=%0d", press_at[0] - t0 - 1, LAT); end
      checks++; if (long_n[0] - l0 !== 1) begin failures++; $display("FAIL long_count got=%0d exp=1", long_n[0] - l0); end
      checks++; if (long_at[0] - press_at[0] !== LONG) begin failures++; $display("FAIL long_delay got=%0d exp=%0d", long_at[0] - press_at[0], LONG); end
      t1 = cyc;
      btn_raw = 2'b00;
      tick(12);
      checks++; if (rel_at[0] !== t1 + 1 + LAT) begin failures++; $display("FAIL long_release_latency got=%0d exp=%0d", rel_at[0] - t1 - 1, LAT); end
      checks++; if (long_n[0] - l0 !== 1) begin failures++; $display("FAIL long_once got=%0d exp=1", long_n[0] - l0); end
      $display("test_long_press: long pulse timing checked");
   endtask

   task automatic test_release_glitch();
      int t0, p0, r0, l0, drops;
      p0 = press_n[0]; r0 = rel_n[0]; l0 = long_n[0];
      drops = 0;
      t0 = cyc;
      btn_raw = 2'b01;
      tick(10);
      btn_raw = 2'b00;
      tick(2);
      btn_raw = 2'b01;
      while (cyc < t0 + 40) begin
         tick(1);
         if (btn_level[0] !== 1'b1) drops++;
      end
      checks++; if (drops !== 0) begin failures++; $display("FAIL glitch_level_drops got=%0d exp=0", drops); end
      checks++; if (rel_n[0] !== r0) begin failures++; $display("FAIL glitch_release got=%0d exp=0", rel_n[0] - r0); end
      checks++; if (press_n[0] - p0 !== 1) begin failures++; $display("FAIL glitch_press got=%0d exp=1", press_n[0] - p0); end
      checks++; if (long_at[0] !== t0 + 1 + LAT + LONG) begin failures++; $display("FAIL glitch_long_time got=%0d exp=%0d", long_at[0] - t0, 1 + LAT + LONG); end
      checks++; if (long_n[0] - l0 !== 1) begin failures++; $display("FAIL glitch_long_count got=%0d exp=1", long_n[0] - l0); end
      btn_raw = 2'b00;
      tick(12);
      checks++; if (rel_n[0] - r0 !== 1) begin failures++; $display("FAIL glitch_final_release got=%0d exp=1", rel_n[0] - r0); end
      $display("test_release_glitch: glitch rejection checked");
   endtask

   task automatic test_simultaneous();
      int t0, p0, p1, r0, r1;
      p0 = press_n[0]; p1 = press_n[1]; r0 = rel_n[0]; r1 = rel_n[1];
      t0 = cyc;
      btn_raw = 2'b11;
      tick(10);
      checks++; if (press_at[0] !== t0 + 1 + LAT) begin failures++; $display("FAIL simul_press0 got=%0d exp=%0d", press_at[0] - t0 - 1, LAT); end
      checks++; if (press_at[1] !== t0 + 1 + LAT) begin failures++; $display("FAIL simul_press1 got=%0d exp=%0d", press_at[1] - t0 - 1, LAT); end
      checks++; if ((press_n[0] - p0 !== 1) || (press_n[1] - p1 !== 1)) begin failures++; $display("FAIL simul_press_count got=%0d,%0d exp=1,1", press_n[0] - p0, press_n[1] - p1); end
      checks++; if (btn_level !== 2'b11) begin failures++; $display("FAIL simul_level got=%b exp=11", btn_level); end
      btn_raw = 2'b00;
      tick(10);
      checks++; if ((rel_n[0] - r0 !== 1) || (rel_n[1] - r1 !== 1)) begin failures++; $display("FAIL simul_release_count got=%0d,%0d exp=1,1", rel_n[0] - r0, rel_n[1] - r1); end
      $display("test_simultaneous: both bits checked");
   endtask

   task automatic test_reset_mid();
      int t1, p0, r0;
      btn_raw = 2'b01;
      tick(10);
      checks++; if (btn_level !== 2'b01) begin failures++; $display("FAIL rstmid_pre_level got=%b exp=01", btn_level); end
      p0 = press_n[0]; r0 = rel_n[0];
      rst = 1'b1;
      tick(1);
      checks++; if ({btn_level, btn_press, btn_release, btn_long} !== 8'h00) begin failures++; $display("FAIL rstmid_outputs got=%b exp=00000000", {btn_level, btn_press, btn_release, btn_long}); end
      rst = 1'b0;
      t1 = cyc;
      tick(10);
      checks++; if (press_n[0] - p0 !== 1) begin failures++; $display("FAIL rstmid_repress_count got=%0d exp=1", press_n[0] - p0); end
      checks++; if (press_at[0] !== t1 + 1 + LAT) begin failures++; $display("FAIL rstmid_repress_latency got=%0d exp=%0d", press_at[0] - t1 - 1, LAT); end
      checks++; if (rel_n[0] !== r0) begin failures++; $display("FAIL rstmid_no_release got=%0d exp=0", rel_n[0] - r0); end
      btn_raw = 2'b00;
      tick(12);
      $display("test_reset_mid: re-detection after reset checked");
   endtask

   initial begin
      test_reset();
      test_clean_press();
      test_bounce();
      test_long_press();
      test_release_glitch();
      test_simultaneous();
      test_reset_mid();
      checks++; if (viol !== 0) begin failures++; $display("FAIL pulse_shape_violations got=%0d exp=0", viol); end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
